// File: rtl/bufid_pkg.sv
`default_nettype none
// bufid_pkg: shared widths and allocator state encodings for the centralized packet buffer.
// Rev 1.0
package bufid_pkg;

  localparam int NUM_PORTS  = 4;
  localparam int BUFID_W    = 9;
  localparam int OUTPORT_W  = 4;
  localparam int BUFID_NUM  = 512;
  localparam int PORT_IDX_W = $clog2(NUM_PORTS);

  typedef enum logic [1:0] {
    ARB_S = 2'd0,
    RD_S  = 2'd1,
    CAP_S = 2'd2
  } alloc_state_e;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// rr_arbiter: combinational rotating-priority picker, first eligible requester after last_grant.
// Rev 1.0
module rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     eligible,
  input  logic [IDX_W-1:0] last_grant,
  output logic [IDX_W-1:0] winner,
  output logic             valid
);

  logic [IDX_W-1:0] cand;

  // Scan from farthest to nearest so the closest eligible port after last_grant wins.
  always_comb begin
    winner = '0;
    valid  = 1'b0;
    cand   = '0;
    for (int k = N; k >= 1; k--) begin
      cand = IDX_W'((int'(last_grant) + k) % N);
      if (eligible[cand]) begin
        winner = cand;
        valid  = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/bufid_alloc_arbiter.sv
`default_nettype none
// bufid_alloc_arbiter: grants free bufids to input ports round-robin and seeds their refcounts.
// Rev 1.0
module bufid_alloc_arbiter
  import bufid_pkg::*;
(
  input  logic                           clk_sys,
  input  logic                           reset_n,
  input  logic                           i_hardware_initial_finish,
  input  logic [NUM_PORTS-1:0]           iv_bufid_req,
  input  logic [NUM_PORTS*OUTPORT_W-1:0] iv_outport_num,
  output logic [NUM_PORTS-1:0]           ov_bufid_ack,
  output logic [BUFID_W-1:0]             ov_bufid,
  output logic                           o_free_bufid_rd,
  input  logic [BUFID_W-1:0]             iv_free_bufid,
  input  logic                           i_free_bufid_empty,
  output logic                           o_cnt_wr,
  output logic [BUFID_W-1:0]             ov_cnt_addr,
  output logic [OUTPORT_W-1:0]           ov_cnt_wdata,
  output logic [1:0]                     ov_alloc_state,
  output logic [15:0]                    ov_alloc_cnt
);

  alloc_state_e            state;
  logic [PORT_IDX_W-1:0]   last_grant;
  logic [PORT_IDX_W-1:0]   win_idx;
  logic [OUTPORT_W-1:0]    win_outport;
  logic [PORT_IDX_W-1:0]   arb_winner;
  logic                    arb_valid;
  logic [NUM_PORTS-1:0]    eligible;
  logic [OUTPORT_W-1:0]    outport_arr [NUM_PORTS];

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_outport
    assign outport_arr[p] = iv_outport_num[p*OUTPORT_W +: OUTPORT_W];
  end

  // The port being acked this cycle still holds req; masking it prevents a double grant.
  assign eligible = iv_bufid_req & ~ov_bufid_ack;

  rr_arbiter #(
    .N     (NUM_PORTS),
    .IDX_W (PORT_IDX_W)
  ) u_rr_arbiter (
    .eligible   (eligible),
    .last_grant (last_grant),
    .winner     (arb_winner),
    .valid      (arb_valid)
  );

  assign ov_alloc_state = state;

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      state           <= ARB_S;
      last_grant      <= PORT_IDX_W'(NUM_PORTS - 1);
      win_idx         <= '0;
      win_outport     <= '0;
      ov_bufid_ack    <= '0;
      ov_bufid        <= '0;
      o_free_bufid_rd <= 1'b0;
      o_cnt_wr        <= 1'b0;
      ov_cnt_addr     <= '0;
      ov_cnt_wdata    <= '0;
      ov_alloc_cnt    <= '0;
    end else begin
      ov_bufid_ack <= '0;
      o_cnt_wr     <= 1'b0;
      case (state)
        ARB_S: begin
          if (arb_valid && i_hardware_initial_finish && !i_free_bufid_empty) begin
            win_idx         <= arb_winner;
            win_outport     <= outport_arr[arb_winner];
            o_free_bufid_rd <= 1'b1;
            state           <= RD_S;
          end
        end
        RD_S: begin
          o_free_bufid_rd <= 1'b0;
          state           <= CAP_S;
        end
        CAP_S: begin
          ov_bufid              <= iv_free_bufid;
          ov_cnt_addr           <= iv_free_bufid;
          // A packet always holds at least one reference until released.
          ov_cnt_wdata          <= (win_outport == '0) ? OUTPORT_W'(1) : win_outport;
          o_cnt_wr              <= 1'b1;
          ov_bufid_ack[win_idx] <= 1'b1;
          last_grant            <= win_idx;
          ov_alloc_cnt          <= ov_alloc_cnt + 16'd1;
          state                 <= ARB_S;
        end
        default: begin
          o_free_bufid_rd <= 1'b0;
          state           <= ARB_S;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bufid_alloc_arbiter.sv
`default_nettype none
// tb_bufid_alloc_arbiter: directed and random checks against a transaction-level allocator model.
// Rev 1.0
module tb_bufid_alloc_arbiter;

  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b0;
  logic        fin = 1'b0;
  logic [3:0]  req = '0;
  logic [15:0] outport_num = '0;
  logic [8:0]  q = '0;
  logic        empty = 1'b1;

  logic [3:0]  ack;
  logic [8:0]  bufid;
  logic        rd;
  logic        cnt_wr;
  logic [8:0]  cnt_addr;
  logic [3:0]  cnt_wdata;
  logic [1:0]  alloc_state;
  logic [15:0] alloc_cnt;

  bufid_alloc_arbiter dut (
    .clk_sys                   (clk_sys),
    .reset_n                   (reset_n),
    .i_hardware_initial_finish (fin),
    .iv_bufid_req              (req),
    .iv_outport_num            (outport_num),
    .ov_bufid_ack              (ack),
    .ov_bufid                  (bufid),
    .o_free_bufid_rd           (rd),
    .iv_free_bufid             (q),
    .i_free_bufid_empty        (empty),
    .o_cnt_wr                  (cnt_wr),
    .ov_cnt_addr               (cnt_addr),
    .ov_cnt_wdata              (cnt_wdata),
    .ov_alloc_state            (alloc_state),
    .ov_alloc_cnt              (alloc_cnt)
  );

  initial forever #5 clk_sys = ~clk_sys;

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  int unsigned fifo[$];
  int unsigned inuse[$];
  bit          alloc_map [512];
  bit          hold_empty = 1'b0;
  bit          ret_en = 1'b0;
  logic [3:0]  auto_req = '0;
  logic [3:0]  ack_seen = '0;

  // Transaction-level model: phase 0 idle, 1 read issued, 2 waiting on FIFO data.
  int          m_phase = 0;
  int          m_win = 0;
  int          m_last = 3;
  logic [3:0]  m_out = '0;
  logic [3:0]  m_ack = '0;
  logic        m_rd = 1'b0;
  logic        m_wr = 1'b0;
  logic [8:0]  m_bufid = '0;
  logic [3:0]  m_wdata = '0;
  logic [15:0] m_cnt = '0;

  int total = 0;
  int bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic update_empty();
    empty = hold_empty || (fifo.size() == 0);
  endtask

  task automatic fifo_reset();
    fifo.delete();
    inuse.delete();
    for (int i = 0; i < 512; i++) alloc_map[i] = 1'b0;
    for (int b = 9; b <= 40; b++) fifo.push_back(b);
    q = '0;
    ack_seen = '0;
    update_empty();
  endtask

  task automatic tick();
    logic [3:0] elig;
    logic       rd_now;
    bit         found;
    int         p;
    int unsigned b;
    rd_now = rd;
    if (!reset_n) begin
      m_phase = 0; m_last = 3; m_ack = '0; m_rd = 1'b0; m_wr = 1'b0;
      m_bufid = '0; m_wdata = '0; m_cnt = '0; m_out = '0; m_win = 0;
    end else begin
      elig  = req & ~m_ack;
      m_ack = '0;
      m_wr  = 1'b0;
      if (m_phase == 1) begin
        m_rd = 1'b0;
        m_phase = 2;
      end else if (m_phase == 2) begin
        m_bufid = q;
        m_wdata = (m_out == 4'd0) ? 4'd1 : m_out;
        m_wr    = 1'b1;
        m_ack   = 4'(1 << m_win);
        m_last  = m_win;
        m_cnt   = m_cnt + 16'd1;
        m_phase = 0;
      end else if (elig != 4'd0 && fin && !empty) begin
        found = 1'b0;
        for (int k = 1; k <= 4; k++) begin
          p = (m_last + k) % 4;
          if (!found && elig[p]) begin
            m_win = p;
            found = 1'b1;
          end
        end
        m_out   = outport_num[m_win*4 +: 4];
        m_rd    = 1'b1;
        m_phase = 1;
      end
    end
    @(posedge clk_sys);
    #1;
    if (!reset_n) fifo_reset();
    else if (rd_now && fifo.size() > 0) q = 9'(fifo.pop_front());
    chk("rd", rd, m_rd);
    chk("ack", ack, m_ack);
    chk("cnt_wr", cnt_wr, m_wr);
    chk("state", alloc_state, m_phase);
    chk("alloc_cnt", alloc_cnt, m_cnt);
    chk("bufid", bufid, m_bufid);
    chk("cnt_addr", cnt_addr, m_bufid);
    chk("cnt_wdata", cnt_wdata, m_wdata);
    if (ack != 4'd0) begin
      chk("ack_onehot", $countones(ack), 1);
      chk("dup_bufid", alloc_map[bufid], 0);
      alloc_map[bufid] = 1'b1;
      inuse.push_back(bufid);
    end
    if (reset_n && ret_en && inuse.size() > 0 && $urandom_range(0, 3) == 0) begin
      b = inuse.pop_front();
      alloc_map[b] = 1'b0;
      fifo.push_back(b);
    end
    for (int i = 0; i < 4; i++) begin
      if (ack_seen[i]) req[i] = 1'b0;
      else if (!req[i] && auto_req[i]) begin
        req[i] = 1'b1;
        outport_num[i*4 +: 4] = 4'($urandom_range(0, 15));
      end
    end
    ack_seen = ack;
    update_empty();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_ack(input string tag, input int port, input int bound, output int cycles);
    bit got;
    got = 1'b0;
    cycles = 0;
    while (!got && cycles < bound) begin
      tick();
      cycles++;
      if (ack[port]) got = 1'b1;
    end
    chk(tag, got, 1);
  endtask

  task automatic wait_rd(input string tag, input int bound);
    bit got;
    int n;
    got = 1'b0;
    n = 0;
    while (!got && n < bound) begin
      tick();
      n++;
      if (rd) got = 1'b1;
    end
    chk(tag, got, 1);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    ticks(3);
    reset_n = 1'b1;
  endtask

  initial begin
    int c;
    int order[$];
    int tstamp[$];
    int cyc;
    fifo_reset();

    // Reset, then hold off grants until the free FIFO preload completes.
    do_reset();
    chk("reset_state", alloc_state, 0);
    chk("reset_cnt", alloc_cnt, 0);
    outport_num[3:0] = 4'd3;
    req = 4'b0001;
    ticks(20);
    chk("no_ack_before_init", ack, 0);
    fin = 1'b1;
    wait_ack("ack0_timeout", 0, 20, c);
    chk("first_latency", c, 3);
    chk("first_bufid", bufid, 9);
    chk("first_addr", cnt_addr, 9);
    chk("first_wdata", cnt_wdata, 3);
    chk("first_wr", cnt_wr, 1);
    ticks(3);

    // Outport count of zero is seeded as one reference.
    outport_num[7:4] = 4'd0;
    req = 4'b0010;
    wait_ack("ack1_timeout", 1, 20, c);
    chk("zero_clamp", cnt_wdata, 1);
    ticks(3);

    // Empty FIFO blocks the read until data is available.
    hold_empty = 1'b1;
    update_empty();
    req = 4'b0100;
    ticks(10);
    chk("no_rd_when_empty", rd, 0);
    hold_empty = 1'b0;
    update_empty();
    wait_ack("ack2_timeout", 2, 20, c);
    chk("empty_release_latency", c, 3);
    ticks(3);

    // All ports continuously requesting: strict rotation, one grant per 3 cycles.
    do_reset();
    auto_req = 4'b1111;
    cyc = 0;
    while (order.size() < 8 && cyc < 80) begin
      tick();
      cyc++;
      if (ack != 4'd0) begin
        for (int i = 0; i < 4; i++) if (ack[i]) order.push_back(i);
        tstamp.push_back(cyc);
      end
    end
    chk("rr_grants_seen", order.size(), 8);
    for (int i = 0; i < order.size(); i++) chk("rr_order", order[i], i % 4);
    for (int i = 1; i < tstamp.size(); i++) chk("rr_spacing", tstamp[i] - tstamp[i-1], 3);
    chk("cnt_after_8", alloc_cnt, 8);
    auto_req = 4'b0000;
    ticks(20);

    // Reset while the read is outstanding discards the allocation.
    req = 4'b0001;
    wait_rd("rd_before_reset", 10);
    reset_n = 1'b0;
    tick();
    chk("midreset_state", alloc_state, 0);
    chk("midreset_ack", ack, 0);
    chk("midreset_rd", rd, 0);
    req = 4'b0000;
    reset_n = 1'b1;
    ticks(5);

    // Request dropped after the read issues still completes.
    outport_num[15:12] = 4'd7;
    req = 4'b1000;
    wait_rd("rd_port3", 10);
    req[3] = 1'b0;
    wait_ack("ack3_after_drop", 3, 10, c);
    chk("drop_wdata", cnt_wdata, 7);
    ticks(3);

    // Random traffic with FIFO returns and sporadic empty.
    ret_en = 1'b1;
    for (int i = 0; i < 400; i++) begin
      auto_req = 4'($urandom_range(0, 15));
      hold_empty = ($urandom_range(0, 7) == 0);
      update_empty();
      tick();
    end
    auto_req = 4'b0000;
    hold_empty = 1'b0;
    update_empty();
    ticks(40);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/bufid_alloc_arbiter.md
# bufid_alloc_arbiter

Allocates packet buffer IDs from the shared free-bufid FIFO to the input-port receive paths. Round-robin arbitrates NUM_PORTS requesters, pops one free bufid per grant, and writes the packet's outport count into the per-bufid reference-count RAM that the release path later decrements. Sits in pkt_centralized_buffer, between the input-port receive logic and the free-bufid FIFO and count RAM.

## Interface
- NUM_PORTS, 4, number of requesting input ports
- BUFID_W, 9, buffer ID width (512 buffers)
- OUTPORT_W, 4, outport-count width
- clk_sys  in  1  system clock; the block's only clock
- reset_n  in  1  synchronous, active-low reset
- i_hardware_initial_finish  in  1  free FIFO preload done; no grants while low
- iv_bufid_req  in  NUM_PORTS  per-port request, level, held until ack
- iv_outport_num  in  NUM_PORTS*OUTPORT_W  per-port outport count; port p in bits [p*4+3:p*4]
- ov_bufid_ack  out  NUM_PORTS  one-cycle grant pulse, one-hot
- ov_bufid  out  BUFID_W  allocated bufid, valid while ack high
- o_free_bufid_rd  out  1  FIFO read request, non-showahead
- iv_free_bufid  in  BUFID_W  FIFO q, valid the cycle after rd
- i_free_bufid_empty  in  1  FIFO empty
- o_cnt_wr  out  1  count RAM write strobe
- ov_cnt_addr  out  BUFID_W  count RAM address
- ov_cnt_wdata  out  OUTPORT_W  count RAM data
- ov_alloc_state  out  2  current FSM state, debug
- ov_alloc_cnt  out  16  grants since reset, wraps 0xFFFF->0

## Operation
- All outputs registered; reset value 0 for every output except ov_alloc_state = ARB_S (2'd0); internal pointer last_grant = NUM_PORTS-1, so port 0 has first priority.
- FSM states: ARB_S=0, RD_S=1, CAP_S=2; encoding 3 is illegal, goes to ARB_S with all strobes cleared.
- ARB_S: eligible = iv_bufid_req & ~ov_bufid_ack. If eligible≠0, i_hardware_initial_finish=1 and i_free_bufid_empty=0: pick first eligible port after last_grant (cyclic), latch its port index and outport_num, set o_free_bufid_rd=1, go RD_S. Otherwise stay; no read. Ack strobes clear in every state except the cycle set by CAP_S.
- RD_S: o_free_bufid_rd<=0; go CAP_S.
- CAP_S: capture iv_free_bufid into ov_bufid and ov_cnt_addr; ov_cnt_wdata = latched outport_num, and 0 is clamped to 1; o_cnt_wr<=1; ov_bufid_ack[winner]<=1; last_grant<=winner; ov_alloc_cnt++; go ARB_S.
- o_cnt_wr and ack are single-cycle, coincident, and cleared in ARB_S.
- A request dropped before grant is ignored; a request dropped after the FSM leaves ARB_S still completes, and the ack is delivered and the count written.
- Empty asserting while in RD_S or CAP_S has no effect; the read was already issued.
- Reset mid-allocation discards the popped bufid; the FIFO and count RAM are reset by the same reset_n.

## Timing
- Edge E0: decision in ARB_S. E1: rd high. E2: q valid, captured. E3: ack and o_cnt_wr high for one cycle.
- Request-to-ack latency is 3 cycles when uncontested. Peak throughput is one grant per 3 cycles.
- The requester must hold req through the ack cycle and drop it the cycle after. The self-mask on ack prevents a double grant.
- Fairness: with all ports continuously requesting, each port receives exactly 1 grant per NUM_PORTS grants.

## Structure
- Shared package bufid_pkg: BUFID_W, OUTPORT_W, NUM_PORTS, state encodings ARB_S/RD_S/CAP_S, BUFID_NUM=512.
- One sub-module: rr_arbiter, a combinational rotating-priority picker (inputs eligible vector and last_grant; outputs winner index and valid). Separate because the release side will reuse it.
- Top level holds the FSM, latches and counters; roughly 150-200 lines total.

## Test plan
- Reset, initial_finish=0, req=4'b0001, FIFO non-empty -> no rd or ack for 20 cycles; raise initial_finish -> ack[0] 3 cycles later, ov_bufid = FIFO head (e.g. 9'd9), o_cnt_wr with addr 9, data = outport_num 3.
- req=4'b1111 held, requesters re-assert after ack -> grant order 0,1,2,3,0,...; ov_alloc_cnt=8 after 8 grants; one grant every 3 cycles.
- FIFO empty with req=4'b0100 -> stays ARB_S, rd never asserted; empty deasserts -> ack[2] at E3.
- outport_num=0 on port 1 -> ack[1] and ov_cnt_wdata=1.
- reset_n low during RD_S -> all outputs 0 and state ARB_S next cycle; no ack issued.
- Port 3 drops req during RD_S -> ack[3] still issued and count written; a bench scoreboard confirms no bufid is granted twice before it is returned.
